// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq
//   Drives a 3-to-8 active-low decoder (decoder38) for row/digit scanning.
//   It steps a 3-bit select through the enabled slots of an 8-bit mask. Each
//   slot first gets a blanking gap, with en_n high so the select can settle,
//   and then a dwell window with en_n low.
// Ports
//   clk_i         rising-edge clock
//   rst_n_i       synchronous active-low reset
//   start_i       begin scanning; only looked at while idle
//   stop_i        end scanning after the current dwell window
//   slot_mask_i   bit i set -> slot i is scanned; re-read at every slot advance
//   dwell_i       enabled cycles per slot (0 acts as 1); read on dwell entry
//   sel_o         decoder select (a=sel[2], c=sel[0])
//   en_n_o        active-low decoder enable
//   busy_o        high while blanking or dwelling
//   frame_done_o  one-cycle pulse on the first blank cycle after a wrap
module decoder_scan_seq #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [7:0]         slot_mask_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [2:0]         sel_o,
    output logic               en_n_o,
    output logic               busy_o,
    output logic               frame_done_o
);

    localparam int BW = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

    state_t             state_q;
    logic [2:0]         sel_q;
    logic               en_n_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               stop_pend_q;
    logic [BW-1:0]      bcnt_q;
    logic [DWELL_W-1:0] dcnt_q;

    logic [2:0] first_slot;
    logic [2:0] next_slot;
    logic [2:0] idx;
    logic       end_scan;

    // first_slot: lowest set mask bit.
    // next_slot: first set bit strictly after sel_q, wrapping 7->0. An offset
    // of 8 truncates to 0, which lets a single-slot mask return sel_q itself.
    // Both loops run downward so the smallest match is written last and wins.
    always_comb begin
        first_slot = 3'd0;
        next_slot  = sel_q;
        idx        = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (slot_mask_i[i]) first_slot = 3'(i);
        for (int k = 8; k >= 1; k--) begin
            idx = sel_q + 3'(k);
            if (slot_mask_i[idx]) next_slot = idx;
        end
    end

    assign end_scan = stop_pend_q | stop_i | (slot_mask_i == 8'h00);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            sel_q        <= 3'd0;
            en_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            bcnt_q       <= '0;
            dcnt_q       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    stop_pend_q <= 1'b0;
                    if (start_i && !stop_i && (slot_mask_i != 8'h00)) begin
                        state_q <= BLANK;
                        sel_q   <= first_slot;
                        bcnt_q  <= BW'(BLANK_CYCLES);
                        busy_q  <= 1'b1;
                    end
                end
                BLANK: begin
                    if (stop_i) stop_pend_q <= 1'b1;
                    if (bcnt_q == BW'(1)) begin
                        state_q <= DWELL;
                        en_n_q  <= 1'b0;
                        dcnt_q  <= (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
                    end else begin
                        bcnt_q <= bcnt_q - BW'(1);
                    end
                end
                DWELL: begin
                    if (dcnt_q == DWELL_W'(1)) begin
                        en_n_q <= 1'b1;
                        if (end_scan) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                        end else begin
                            // A next slot at or below the current one means the scan wrapped.
                            state_q      <= BLANK;
                            sel_q        <= next_slot;
                            bcnt_q       <= BW'(BLANK_CYCLES);
                            frame_done_q <= (next_slot <= sel_q);
                        end
                    end else begin
                        dcnt_q <= dcnt_q - DWELL_W'(1);
                        if (stop_i) stop_pend_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel_o        = sel_q;
    assign en_n_o       = en_n_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule
